// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: host start pulse, 40-bit response timing, checksum validation.
// Define DHT_HOLDOFF_EN to enforce a HOLDOFF_MS quiet period between o_done and the next accepted start.
module dht11_reader #(
    parameter int CLK_FREQ_HZ      = 50000000,
    parameter int START_LOW_US     = 18000,
    parameter int TIMEOUT_US       = 100,
    parameter int BIT_THRESHOLD_US = 50,
    parameter int HOLDOFF_MS       = 1000
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        dht_data,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_hum_int,
    output logic [7:0] o_hum_dec,
    output logic [7:0] o_temp_int,
    output logic [7:0] o_temp_dec,
    output logic       o_checksum_err,
    output logic       o_timeout_err
);

    localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
    localparam int START_CYC   = START_LOW_US * CYC_PER_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_PER_US;
    localparam int THRESH_CYC  = BIT_THRESHOLD_US * CYC_PER_US;
    localparam int CNT_W       = $clog2(START_CYC + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] THRESH_LIM   = CNT_W'(THRESH_CYC);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_TERR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [39:0]      shift_q, shift_d;
    logic [1:0]       sync_q, sync_d;
    logic             line_prev_q, line_prev_d;
    logic             drive_q, drive_d;
    logic [7:0]       hum_int_q, hum_int_d;
    logic [7:0]       hum_dec_q, hum_dec_d;
    logic [7:0]       temp_int_q, temp_int_d;
    logic [7:0]       temp_dec_q, temp_dec_d;
    logic             cks_err_q, cks_err_d;
    logic             tout_err_q, tout_err_d;

    logic             line_fall;
    logic             line_rise;
    logic             wait_expired;
    logic             bit_val;
    logic             start_ok;
    logic [7:0]       sum;

    // Open-drain pad: only ever pull low, the external pull-up supplies the high level
    assign dht_data = drive_q ? 1'b0 : 1'bz;

    always_comb begin
        sync_d       = {sync_q[0], dht_data};
        line_prev_d  = sync_q[1];
        line_fall    = line_prev_q & ~sync_q[1];
        line_rise    = ~line_prev_q & sync_q[1];
        wait_expired = (cnt_q >= TIMEOUT_LIM);
        // cnt_q lags the true high width by one cycle at the falling edge
        bit_val      = (cnt_q >= THRESH_LIM);
        sum          = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    end

`ifdef DHT_HOLDOFF_EN
    localparam int HOLD_US = HOLDOFF_MS * 1000;
    localparam int HOLD_W  = $clog2(HOLD_US + 1);
    localparam int DIV_W   = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    logic [DIV_W-1:0]  us_div_q, us_div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              us_tick;

    always_comb begin
        us_tick  = (us_div_q == DIV_W'(CYC_PER_US - 1));
        us_div_d = us_tick ? '0 : us_div_q + 1'b1;
        hold_d   = hold_q;
        if (state_q == S_DONE) begin
            hold_d = HOLD_W'(HOLD_US);
        end else if (us_tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end
        start_ok = i_start && (hold_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            us_div_q <= '0;
            hold_q   <= '0;
        end else begin
            us_div_q <= us_div_d;
            hold_q   <= hold_d;
        end
    end
`else
    logic unused_holdoff;

    always_comb begin
        start_ok       = i_start;
        unused_holdoff = ^HOLDOFF_MS;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sensor edge wins over an expiring timer on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_START_LOW;
            end
            S_START_LOW: begin
                if (cnt_q == START_LAST) state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (line_fall)         state_d = S_RESP_LOW;
                else if (wait_expired) state_d = S_TERR;
            end
            S_RESP_LOW: begin
                if (line_rise)         state_d = S_RESP_HIGH;
                else if (wait_expired) state_d = S_TERR;
            end
            S_RESP_HIGH: begin
                if (line_fall)         state_d = S_BIT_LOW;
                else if (wait_expired) state_d = S_TERR;
            end
            S_BIT_LOW: begin
                if (line_rise)         state_d = S_BIT_HIGH;
                else if (wait_expired) state_d = S_TERR;
            end
            S_BIT_HIGH: begin
                if (line_fall)         state_d = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (wait_expired) state_d = S_TERR;
            end
            S_CHECK: state_d = S_DONE;
            S_TERR:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        drive_d    = (state_d == S_START_LOW);
        hum_int_d  = hum_int_q;
        hum_dec_d  = hum_dec_q;
        temp_int_d = temp_int_q;
        temp_dec_d = temp_dec_q;
        cks_err_d  = cks_err_q;
        tout_err_d = tout_err_q;

        if ((state_q == S_IDLE) || (state_d != state_q)) begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    cks_err_d  = 1'b0;
                    tout_err_d = 1'b0;
                end
            end
            S_RESP_HIGH: begin
                if (state_d == S_BIT_LOW) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_BIT_HIGH: begin
                if (line_fall) begin
                    shift_d   = {shift_q[38:0], bit_val};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                hum_int_d  = shift_q[39:32];
                hum_dec_d  = shift_q[31:24];
                temp_int_d = shift_q[23:16];
                temp_dec_d = shift_q[15:8];
                cks_err_d  = (sum != shift_q[7:0]);
            end
            S_TERR: begin
                tout_err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Synchroniser resets to the idle (pulled-up) level so reset never fakes an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
            drive_q     <= 1'b0;
            hum_int_q   <= '0;
            hum_dec_q   <= '0;
            temp_int_q  <= '0;
            temp_dec_q  <= '0;
            cks_err_q   <= 1'b0;
            tout_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            line_prev_q <= line_prev_d;
            drive_q     <= drive_d;
            hum_int_q   <= hum_int_d;
            hum_dec_q   <= hum_dec_d;
            temp_int_q  <= temp_int_d;
            temp_dec_q  <= temp_dec_d;
            cks_err_q   <= cks_err_d;
            tout_err_q  <= tout_err_d;
        end
    end

    assign o_hum_int      = hum_int_q;
    assign o_hum_dec      = hum_dec_q;
    assign o_temp_int     = temp_int_q;
    assign o_temp_dec     = temp_dec_q;
    assign o_checksum_err = cks_err_q;
    assign o_timeout_err  = tout_err_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Testbench for dht11_reader: table-driven sensor frames plus reset, busy and holdoff sequences.
// The host start pulse is shortened to START_LOW_US cycles to keep the run brief.
module tb_dht11_reader;

    localparam int CLK_FREQ_HZ      = 1000000;
    localparam int START_LOW_US     = 2000;
    localparam int TIMEOUT_US       = 100;
    localparam int BIT_THRESHOLD_US = 50;
    localparam int HOLDOFF_MS       = 1;

    logic       clock;
    logic       reset;
    logic       i_start;
    logic       sensor_low;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_hum_int;
    logic [7:0] o_hum_dec;
    logic [7:0] o_temp_int;
    logic [7:0] o_temp_dec;
    logic       o_checksum_err;
    logic       o_timeout_err;
    wire        dht_line;

    pullup (dht_line);
    assign dht_line = sensor_low ? 1'b0 : 1'bz;

    dht11_reader #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .START_LOW_US    (START_LOW_US),
        .TIMEOUT_US      (TIMEOUT_US),
        .BIT_THRESHOLD_US(BIT_THRESHOLD_US),
        .HOLDOFF_MS      (HOLDOFF_MS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dht_data      (dht_line),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_hum_int     (o_hum_int),
        .o_hum_dec     (o_hum_dec),
        .o_temp_int    (o_temp_int),
        .o_temp_dec    (o_temp_dec),
        .o_checksum_err(o_checksum_err),
        .o_timeout_err (o_timeout_err)
    );

    typedef struct {
        logic [39:0] frame;
        int          hi0;
        int          hi1;
        bit          respond;
        bit          poke_busy;
        logic [7:0]  exp_hum_int;
        logic [7:0]  exp_hum_dec;
        logic [7:0]  exp_temp_int;
        logic [7:0]  exp_temp_dec;
        bit          exp_cks_err;
        bit          exp_tout_err;
    } vec_t;

    vec_t vecs [4];
    int   checks;
    int   errors;
    int   cyc;
    int   done_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (o_done === 1'b1) done_count <= done_count + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic hold_line(input bit low, input int n);
        sensor_low = low;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    // One full read: idle gap, start pulse, host-low measurement, sensor reply, result checks
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   low_cycles;
        int   start_cyc;
        int   base_done;
        v = vecs[idx];
        repeat (1100) @(negedge clock);
        base_done = done_count;
        i_start   = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        i_start    = 1'b0;
        low_cycles = 0;
        while (dht_line == 1'b0 && low_cycles < START_LOW_US + 50) begin
            low_cycles++;
            @(negedge clock);
        end
        checkRange($sformatf("v%0d host low cycles", idx), low_cycles, START_LOW_US, START_LOW_US + 2);
        if (v.respond) begin
            repeat (30) @(negedge clock);
            hold_line(1'b1, 80);
            hold_line(1'b0, 80);
            for (int b = 39; b >= 0; b--) begin
                if (v.poke_busy && b == 20) begin
                    checkOutput($sformatf("v%0d busy mid-read", idx), o_busy, 1);
                    i_start = 1'b1;
                    hold_line(1'b1, 1);
                    i_start = 1'b0;
                    hold_line(1'b1, 49);
                end else begin
                    hold_line(1'b1, 50);
                end
                hold_line(1'b0, v.frame[b] ? v.hi1 : v.hi0);
            end
            sensor_low = 1'b1;
        end
        wait_done(600);
        checkOutput($sformatf("v%0d done seen", idx), o_done, 1);
        if (v.exp_tout_err) begin
            checkRange($sformatf("v%0d timeout latency", idx), cyc - start_cyc,
                       START_LOW_US + TIMEOUT_US, START_LOW_US + TIMEOUT_US + 10);
        end
        checkOutput($sformatf("v%0d busy at done", idx), o_busy, 0);
        checkOutput($sformatf("v%0d hum_int", idx), o_hum_int, v.exp_hum_int);
        checkOutput($sformatf("v%0d hum_dec", idx), o_hum_dec, v.exp_hum_dec);
        checkOutput($sformatf("v%0d temp_int", idx), o_temp_int, v.exp_temp_int);
        checkOutput($sformatf("v%0d temp_dec", idx), o_temp_dec, v.exp_temp_dec);
        checkOutput($sformatf("v%0d checksum_err", idx), o_checksum_err, v.exp_cks_err);
        checkOutput($sformatf("v%0d timeout_err", idx), o_timeout_err, v.exp_tout_err);
        hold_line(1'b1, 5);
        sensor_low = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput($sformatf("v%0d done pulses", idx), done_count - base_done, 1);
        checkOutput($sformatf("v%0d busy after", idx), o_busy, 0);
        checkOutput($sformatf("v%0d line released", idx), dht_line, 1);
    endtask

    initial begin
        int base_done;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        done_count = 0;
        reset      = 1'b1;
        i_start    = 1'b0;
        sensor_low = 1'b0;

        vecs[0] = '{40'h37_00_19_05_55, 26, 70, 1'b1, 1'b1, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b0};
        vecs[1] = '{40'h37_00_19_05_56, 26, 70, 1'b1, 1'b0, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 1'b0};
        vecs[2] = '{40'h00_00_00_00_00, 26, 70, 1'b0, 1'b0, 8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b1};
        vecs[3] = '{40'hA5_3C_5A_01_3C, 50, 51, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h5A, 8'h01, 1'b0, 1'b0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset line", dht_line, 1);
        checkOutput("reset busy", o_busy, 0);
        checkOutput("reset done", o_done, 0);
        checkOutput("reset data", {o_hum_int, o_hum_dec, o_temp_int, o_temp_dec}, 32'h0);
        checkOutput("reset flags", {o_checksum_err, o_timeout_err}, 0);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(i);
        end

`ifdef DHT_HOLDOFF_EN
        repeat (1100) @(negedge clock);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        wait_done(START_LOW_US + 400);
        checkOutput("holdoff read done", o_done, 1);
        repeat (500) @(negedge clock);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        checkOutput("holdoff early start ignored", o_busy, 0);
        repeat (500) @(negedge clock);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        checkOutput("holdoff late start accepted", o_busy, 1);
        wait_done(START_LOW_US + 400);
        checkOutput("holdoff second done", o_done, 1);
`endif

        repeat (1100) @(negedge clock);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        repeat (100) @(negedge clock);
        checkOutput("mid-read line low", dht_line, 0);
        checkOutput("mid-read busy", o_busy, 1);
        base_done = done_count;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort line released", dht_line, 1);
        checkOutput("abort busy", o_busy, 0);
        checkOutput("abort data cleared", {o_hum_int, o_hum_dec, o_temp_int, o_temp_dec}, 32'h0);
        repeat (300) @(negedge clock);
        checkOutput("abort no done", done_count - base_done, 0);
        checkOutput("abort line idle", dht_line, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Single-wire DHT11 sensor reader.
- Sits upstream of the UART transmit path: on a start request it drives the sensor start pulse, times the 40-bit response, and validates the checksum.
- Presents humidity and temperature bytes with a one-cycle done strobe, ready for serialisation to uart_tx.
- Owns the bidirectional dht_data pad, open-drain style.

Parameters:
- CLK_FREQ_HZ, 50000000, clock frequency; cycles per µs = CLK_FREQ_HZ/1000000.
- START_LOW_US, 18000, host start pulse low time.
- TIMEOUT_US, 100, maximum time allowed in any wait-for-edge state.
- BIT_THRESHOLD_US, 50, high time strictly greater than this decodes as 1, otherwise 0.
- HOLDOFF_MS, 1000, minimum time from done to the next accepted start (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dht_data  inout  1  sensor line; driven 0 or released to Z, never driven 1
- i_start  in  1  request a read; sampled only in IDLE
- o_busy  out  1  high from the accepted start until the done strobe
- o_done  out  1  one-cycle pulse at the end of every read attempt (success or error)
- o_hum_int  out  8  humidity integer byte
- o_hum_dec  out  8  humidity decimal byte
- o_temp_int  out  8  temperature integer byte
- o_temp_dec  out  8  temperature decimal byte
- o_checksum_err  out  1  last read failed the checksum
- o_timeout_err  out  1  last read timed out

Behaviour:
- Reset (synchronous, active-high): state IDLE, dht_data released (Z), all outputs 0, counters and shift register cleared. Reset mid-read aborts at once, releases the line, and produces no o_done.
- Input sampling: dht_data passes through a 2-flop synchroniser; edge detection uses the synchronised value (2-cycle latency). Line is assumed pulled up externally.
- One free-running µs-tick counter plus one cycle counter, sized with $clog2 for START_LOW_US × cycles/µs.
- States:
  - IDLE: i_start=1 → START_LOW. On entry, clear both error flags and assert o_busy.
  - START_LOW: drive 0 for START_LOW_US, then release → WAIT_RESP.
  - WAIT_RESP: wait for sensor falling edge → RESP_LOW.
  - RESP_LOW: wait for rising edge → RESP_HIGH.
  - RESP_HIGH: wait for falling edge → BIT_LOW, with bit count = 0.
  - BIT_LOW: wait for rising edge; clear the width counter → BIT_HIGH.
  - BIT_HIGH: count cycles high; on the falling edge shift in (width > BIT_THRESHOLD_US ? 1 : 0), MSB first, and increment bit count. Bit 40 → CHECK, else → BIT_LOW. Width exactly equal to the threshold decodes 0.
  - CHECK: sum = (b0+b1+b2+b3) mod 256. Load the four data outputs with the received bytes regardless of the result; o_checksum_err = (sum != b4). Next cycle → DONE.
  - DONE: o_done=1 for one cycle, o_busy=0 → IDLE.
- Timeout: any wait state (WAIT_RESP through BIT_HIGH) exceeding TIMEOUT_US → TERR. TERR sets o_timeout_err=1 and leaves data outputs unchanged → DONE.
- i_start while busy: ignored and not queued.
- Error flags hold until the next accepted start.

Optional Feature:
- Macro: DHT_HOLDOFF_EN.
- Defined: a holdoff counter starts at every o_done; i_start is ignored until HOLDOFF_MS elapses. The counter is cleared by reset, so the first start after reset is accepted immediately.
- Undefined: i_start is accepted on any IDLE cycle and no holdoff logic is synthesised.

Test Plan:
- Reset: assert reset 3 cycles → dht_data=Z, o_busy=0, o_done=0, all data 0, both flags 0; a start pulse mid-read followed by reset → line Z next cycle, no o_done.
- Good frame (CLK_FREQ_HZ=1000000): pulse i_start. Expect dht_data low ≥18000 cycles. Sensor model replies 80/80 µs, then bytes 0x37,0x00,0x19,0x05,0x55 with bit highs of 26 µs (0) / 70 µs (1). Expect one o_done pulse; hum_int=0x37, temp_int=0x19, temp_dec=0x05, both flags 0.
- Bad checksum: same frame with checksum 0x56 → o_checksum_err=1, data = 0x37/0x00/0x19/0x05, o_done pulses.
- No response: sensor silent → o_timeout_err=1 at about 18000+100 cycles plus sync latency, data keeps previous values, one o_done.
- Threshold boundary: a bit high of exactly 50 µs decodes 0; 51 µs decodes 1.
- Start while busy is ignored (one o_done only). With DHT_HOLDOFF_EN, HOLDOFF_MS=1: start at 500 cycles after done ignored, start at 1001 cycles accepted.
